// File: rtl/ringbuf_arbiter.sv
// ringbuf_arbiter: round-robin write arbiter in front of a shared ring buffer.
// It picks one of NREQ write requesters each cycle, strobes the buffer
// write/read ports and tracks occupancy. A small RUN / DRAIN / FLUSH controller
// can stop intake until the buffer empties, or discard the buffer contents
// and reset the buffer.
module ringbuf_arbiter #(
   parameter int WIDTH = 4,
   parameter int SIZE  = 20,
   parameter int NREQ  = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NREQ-1:0]             i_req,
   input  logic [NREQ*WIDTH-1:0]       i_data,
   output logic [NREQ-1:0]             o_gnt,
   output logic                        o_we,
   output logic [WIDTH-1:0]            o_wdata,
   input  logic                        i_pop,
   output logic                        o_re,
   input  logic                        i_flush,
   input  logic                        i_drain,
   output logic                        o_buf_rst_n,
   output logic [$clog2(SIZE+1)-1:0]   o_count,
   output logic                        o_full,
   output logic                        o_empty,
   output logic                        o_drained
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(SIZE+1);
   localparam logic [NREQ-1:0] ONE_N = NREQ'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t            state_reg;
   logic [PW-1:0]     ptr_reg;
   logic [PW-1:0]     ptr_next;
   logic [CW-1:0]     count_reg;
   logic              buf_rst_n_reg;

   logic              write_ok;
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic [NREQ-1:0]   pick_rot;
   logic [2*NREQ-1:0] gnt_dbl;
   logic [NREQ-1:0]   gnt;
   logic [PW-1:0]     gnt_idx;
   logic [WIDTH-1:0]  data_masked [NREQ];
   logic [WIDTH-1:0]  wdata;

   // Occupancy flags come straight from the counter.
   assign o_full  = (count_reg == CW'(SIZE));
   assign o_empty = (count_reg == '0);

   // A pop on an empty buffer or during the flush cycle is dropped.
   assign o_re = i_pop & ~o_empty & (state_reg != ST_FLUSH);

   // A write fits if there is room, or if a simultaneous read frees a slot.
   assign write_ok = (state_reg == ST_RUN) & (~o_full | o_re);

   // Rotate the request vector so that the requester at ptr lands on bit 0.
   // Duplicating the vector makes the rotation a plain shift for any NREQ,
   // including non-powers of two.
   assign req_dbl = {i_req, i_req};
   assign req_rot = NREQ'(req_dbl >> ptr_reg);

   // Lowest set bit of the rotated vector = highest-priority requester.
   assign pick_rot = req_rot & (~req_rot + ONE_N);

   // Rotate the one-hot pick back and fold the wrapped half onto the low half.
   assign gnt_dbl = {{NREQ{1'b0}}, pick_rot} << ptr_reg;
   assign gnt     = write_ok ? (gnt_dbl[NREQ-1:0] | gnt_dbl[2*NREQ-1:NREQ]) : '0;

   // Binary index of the granted requester, used to advance the pointer.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_idx = PW'(i);
         end
      end
   end

   // The requester after the winner gets top priority next time.
   assign ptr_next = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);

   // Per-requester payload gating; only the granted slot passes its data.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_mask
         assign data_masked[gi] = gnt[gi] ? i_data[gi*WIDTH +: WIDTH] : '0;
      end
   endgenerate

   // OR the gated payloads together; the result is all zeros when nothing is granted.
   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         wdata = wdata | data_masked[i];
      end
   end

   assign o_gnt       = gnt;
   assign o_we        = |gnt;
   assign o_wdata     = wdata;
   assign o_count     = count_reg;
   assign o_buf_rst_n = buf_rst_n_reg;
   assign o_drained   = (state_reg == ST_DRAIN) & o_empty;

   // Control FSM plus the registered buffer reset, which is held low for the
   // cycle after a reset edge and for the cycle after the flush cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= ST_RUN;
         buf_rst_n_reg <= 1'b0;
      end else begin
         buf_rst_n_reg <= (state_reg != ST_FLUSH);
         case (state_reg)
            ST_RUN: begin
               if (i_flush) begin
                  state_reg <= ST_FLUSH;
               end else if (i_drain) begin
                  state_reg <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (i_flush) begin
                  state_reg <= ST_FLUSH;
               end else if (!i_drain) begin
                  state_reg <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               state_reg <= ST_RUN;
            end
            default: begin
               state_reg <= ST_RUN;
            end
         endcase
      end
   end

   // Occupancy counter and priority pointer; both return to zero when the flush cycle ends.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_reg <= '0;
         ptr_reg   <= '0;
      end else if (state_reg == ST_FLUSH) begin
         count_reg <= '0;
         ptr_reg   <= '0;
      end else begin
         if (o_we && !o_re) begin
            count_reg <= count_reg + CW'(1);
         end else if (o_re && !o_we) begin
            count_reg <= count_reg - CW'(1);
         end
         if (o_we) begin
            ptr_reg <= ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_ringbuf_arbiter.sv
// Testbench for ringbuf_arbiter: directed scenarios followed by a random
// phase. Every cycle is checked against a behavioural model that keeps the
// occupancy, the priority pointer and the mode as plain integers.
module tb_ringbuf_arbiter;

   localparam int WIDTH = 4;
   localparam int SIZE  = 20;
   localparam int NREQ  = 4;
   localparam int CW    = $clog2(SIZE+1);
   localparam int DW    = NREQ*WIDTH;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_FLUSH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [NREQ-1:0] req;
   logic [DW-1:0]   data;
   logic            pop;
   logic            flush;
   logic            drain;

   logic [NREQ-1:0]  o_gnt;
   logic             o_we;
   logic [WIDTH-1:0] o_wdata;
   logic             o_re;
   logic             o_buf_rst_n;
   logic [CW-1:0]    o_count;
   logic             o_full;
   logic             o_empty;
   logic             o_drained;

   ringbuf_arbiter #(
      .WIDTH(WIDTH),
      .SIZE (SIZE),
      .NREQ (NREQ)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_data      (data),
      .o_gnt       (o_gnt),
      .o_we        (o_we),
      .o_wdata     (o_wdata),
      .i_pop       (pop),
      .o_re        (o_re),
      .i_flush     (flush),
      .i_drain     (drain),
      .o_buf_rst_n (o_buf_rst_n),
      .o_count     (o_count),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_drained   (o_drained)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model state
   int m_mode;
   int m_ptr;
   int m_count;
   bit m_rstn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: inputs are already applied; check outputs at negedge, then
   // advance the model at the rising edge and return 1ns after it.
   task automatic cycle();
      int k;
      bit full, empty, re, wok, we;
      logic [NREQ-1:0]  egnt;
      logic [WIDTH-1:0] ewd;
      @(negedge clk);
      full  = (m_count == SIZE);
      empty = (m_count == 0);
      re    = pop && !empty && (m_mode != M_FLUSH);
      wok   = (m_mode == M_RUN) && (!full || re);
      k     = -1;
      egnt  = '0;
      ewd   = '0;
      if (wok) begin
         for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (m_ptr + i) % NREQ;
            if (k < 0 && req[c]) k = c;
         end
      end
      if (k >= 0) begin
         egnt[k] = 1'b1;
         ewd     = data[k*WIDTH +: WIDTH];
      end
      we = (k >= 0);
      chk("gnt",     32'(o_gnt),       32'(egnt));
      chk("we",      32'(o_we),        32'(we));
      chk("wdata",   32'(o_wdata),     32'(ewd));
      chk("re",      32'(o_re),        32'(re));
      chk("count",   32'(o_count),     32'(m_count));
      chk("full",    32'(o_full),      32'(full));
      chk("empty",   32'(o_empty),     32'(empty));
      chk("drained", 32'(o_drained),   32'((m_mode == M_DRAIN) && empty));
      chk("buf_rstn",32'(o_buf_rst_n), 32'(m_rstn));
      $display("[TB] cyc=%0d rst=%b req=%b pop=%b drain=%b flush=%b gnt=%b we=%b re=%b count=%0d",
               cyc, rst, req, pop, drain, flush, o_gnt, o_we, o_re, o_count);
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_mode  = M_RUN;
         m_ptr   = 0;
         m_count = 0;
         m_rstn  = 1'b0;
      end else begin
         m_rstn = (m_mode != M_FLUSH);
         if (m_mode == M_FLUSH) begin
            m_count = 0;
            m_ptr   = 0;
            m_mode  = M_RUN;
         end else begin
            m_count = m_count + int'(we) - int'(re);
            if (we) m_ptr = (k + 1) % NREQ;
            if (flush)                         m_mode = M_FLUSH;
            else if (m_mode == M_RUN && drain)   m_mode = M_DRAIN;
            else if (m_mode == M_DRAIN && !drain) m_mode = M_RUN;
         end
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; req = '0; data = '0; pop = 1'b0; flush = 1'b0; drain = 1'b0;
      m_mode = M_RUN; m_ptr = 0; m_count = 0; m_rstn = 1'b0;
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;

      // Round-robin order with all requesters active
      for (int n = 0; n < 8; n++) begin
         req = '1; data = DW'($urandom);
         cycle();
      end
      chk("count_after_8", 32'(o_count), 32'd8);

      // Fill to full
      for (int n = 0; n < 40 && m_count < SIZE; n++) begin
         req = 4'b0001; data = DW'($urandom);
         cycle();
      end
      chk("full_reached", 32'(o_full), 32'd1);
      req = 4'b0001; data = DW'($urandom);
      cycle();
      pop = 1'b1; data = DW'($urandom);
      cycle();
      chk("full_pop_count", 32'(o_count), 32'(SIZE));

      // Pop down to 5
      req = '0;
      for (int n = 0; n < 40 && m_count > 5; n++) cycle();
      chk("count_at_5", 32'(o_count), 32'd5);

      // Drain with pops and a pending request
      drain = 1'b1; req = 4'b0001; pop = 1'b1; data = DW'($urandom);
      for (int n = 0; n < 8; n++) cycle();
      chk("drained_flag", 32'(o_drained), 32'd1);
      chk("drained_count", 32'(o_count), 32'd0);
      drain = 1'b0; pop = 1'b0;
      cycle();
      cycle();
      chk("resume_count", 32'(o_count), 32'd1);

      // Reach count 7 with ptr at 2, then flush
      for (int n = 0; n < 40 && m_count < 6; n++) begin
         req = 4'b0001; data = DW'($urandom);
         cycle();
      end
      req = 4'b0010; data = DW'($urandom);
      cycle();
      chk("pre_flush_count", 32'(o_count), 32'd7);
      req = '0; flush = 1'b1;
      cycle();
      flush = 1'b0; req = '1; pop = 1'b1; data = DW'($urandom);
      cycle();
      pop = 1'b0;
      chk("flush_rstn", 32'(o_buf_rst_n), 32'd0);
      chk("flush_count", 32'(o_count), 32'd0);
      chk("flush_ptr0", 32'(o_gnt), 32'd1);
      cycle();

      // Reset while draining with occupancy 3
      for (int n = 0; n < 40 && m_count < 3; n++) begin
         req = 4'b0001; data = DW'($urandom);
         cycle();
      end
      req = '0; drain = 1'b1;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0; drain = 1'b0;
      chk("rst_drain_count", 32'(o_count), 32'd0);
      chk("rst_drain_rstn", 32'(o_buf_rst_n), 32'd0);
      req = 4'b0001; data = DW'($urandom);
      cycle();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         req   = NREQ'($urandom);
         data  = DW'($urandom);
         pop   = ($urandom_range(0, 99) < 40);
         flush = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 6) drain = ~drain;
         rst   = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ringbuf_arbiter.md
RINGBUF_ARBITER -- requirements
Module: ringbuf_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 4, entry data width; SIZE, 20, entries in the shared ring buffer; NREQ, 4, number of write requesters (2..8).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  NREQ  per-requester write request; bit k = requester k.
REQ-005 i_data  input  NREQ*WIDTH  requester payloads; requester k at bits [k*WIDTH +: WIDTH].
REQ-006 o_gnt  output  NREQ  one-hot grant, combinational; requester k's write accepted at this edge.
REQ-007 o_we / o_wdata  output  1 / WIDTH  buffer write strobe and muxed payload of granted requester.
REQ-008 i_pop  input  1  consumer read request; o_re  output  1  buffer read strobe.
REQ-009 i_flush  input  1  discard all buffer contents; i_drain  input  1  stop accepting writes until empty.
REQ-010 o_buf_rst_n  output  1  active-low reset to the buffer, registered.
REQ-011 o_count  output  $clog2(SIZE+1)  occupancy; o_full, o_empty, o_drained  output  1 each.

Function
REQ-012 Arbitration SHALL be round-robin: priority pointer ptr (0..NREQ-1); highest priority = requester ptr, then ptr+1, ... wrapping mod NREQ.
REQ-013 o_gnt SHALL have at most one bit set, only for a requesting bit, and only when write_ok is true.
REQ-014 write_ok = (state==RUN) & (~o_full | o_re).
REQ-015 o_we = |o_gnt; o_wdata = payload of granted requester, all zeros when o_we=0.
REQ-016 On a cycle with grant to k, ptr SHALL become (k+1) mod NREQ at the edge; without grant, ptr unchanged.
REQ-017 o_re = i_pop & ~o_empty & (state!=FLUSH); pop on empty SHALL be ignored, no count change.
REQ-018 o_count SHALL update at the edge: +1 on o_we only, -1 on o_re only, unchanged on both or neither; never exceeds SIZE or underflows.
REQ-019 o_full = (o_count==SIZE); o_empty = (o_count==0); both combinational from o_count.
REQ-020 FSM states: RUN, DRAIN, FLUSH.
REQ-021 RUN -> FLUSH on i_flush; RUN -> DRAIN on i_drain (flush takes precedence when both).
REQ-022 DRAIN: no grants; pops proceed; o_drained = 1 while in DRAIN and o_empty; DRAIN -> RUN when i_drain deasserts; DRAIN -> FLUSH on i_flush.
REQ-023 FLUSH: lasts exactly one cycle; no grants, o_re=0; o_buf_rst_n=0 during the following cycle (registered); o_count cleared to 0 and ptr to 0 at the FLUSH exit edge; FLUSH -> RUN unconditionally.
REQ-024 o_drained SHALL be 0 in RUN and FLUSH.
REQ-025 Full with simultaneous pop SHALL accept one write; o_count stays SIZE.
REQ-026 Requests arriving in FLUSH/DRAIN SHALL not be granted and SHALL not move ptr; requesters hold i_req until granted.

Reset
REQ-027 i_rst high at an edge SHALL set state=RUN, ptr=0, o_count=0, and o_buf_rst_n=0 for that cycle and the next, overriding all other inputs.
REQ-028 After reset: o_gnt=0, o_we=0, o_re=0, o_empty=1, o_full=0, o_drained=0, o_buf_rst_n=1 from second cycle after i_rst deasserts.
REQ-029 Reset asserted mid-operation (any state, any occupancy) SHALL discard all state identically to power-up reset.

Verification
REQ-030 Reset, then i_req=4'b1111 held 8 cycles, no pops -> grants 0,1,2,3,0,1,2,3; o_count 1..8.
REQ-031 SIZE=20: fill to 20 -> o_full=1, o_gnt=0 with i_req=1; same cycle add i_pop=1 -> one grant, o_re=1, o_count stays 20.
REQ-032 o_count=0, i_pop=1 -> o_re=0, o_count stays 0, o_empty=1.
REQ-033 o_count=5, i_drain=1, i_pop=1 with i_req=4'b0001 -> no grants, count 4..0, o_drained=1 at count 0; drop i_drain -> RUN, grant resumes next cycle.
REQ-034 o_count=7, ptr=2, i_flush pulse -> one FLUSH cycle with o_gnt=0, o_re=0; next cycle o_buf_rst_n=0, o_count=0, ptr=0.
REQ-035 i_rst asserted during DRAIN with o_count=3 -> next cycle state RUN, o_count=0, o_buf_rst_n=0.
